smc_apb_regbank: RTL and testbench

SMC_APB_REGBANK -- requirements
Module: smc_apb_regbank

---
 rtl/smc_apb_regbank.sv | 204 ++++++++++++++++++++
 tb/tb_smc_apb_regbank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/smc_apb_regbank.sv
// ---------------------------------------------------------------------------
// smc_apb_regbank
//   APB slave register bank for the static memory controller. It holds
//   NUM_CS per-chip-select 32-bit config registers, a CTRL register (LOCK and
//   UPDATE bits) and a read-only STATUS window onto i_smc_status. Every access
//   is stretched by WAIT_STATES wait cycles.
//
//   Word map (byte address, bits [1:0] ignored):
//     4*i          CFG[i]   read/write, write ignored while locked
//     4*NUM_CS     CTRL     bit0 LOCK (set-only), bit1 UPDATE (pulse, reads 0)
//     4*NUM_CS+4   STATUS   read-only
//
//   Optional feature macro: SMC_APB_PSLVERR_EN
//     defined   : o_pslverr flags unmapped accesses, STATUS writes and CFG
//                 writes while locked (asserted together with o_pready)
//     undefined : o_pslverr is tied low, those accesses are silently ignored
//
// Ports
//   i_pclk, i_preset            clock, synchronous active-high reset
//   i_psel/i_penable/i_pwrite   APB control
//   i_paddr [ADDR_W]            APB byte address
//   i_pwdata[32]                APB write data
//   i_smc_status[32]            controller status, visible at STATUS
//   o_prdata[32]                read data (zero outside a completing read)
//   o_pready, o_pslverr         APB completion / error
//   o_cfg_regs[32*NUM_CS]       CFG[i] on bits [32*i+31:32*i]
//   o_cfg_lock                  lock state
//   o_cfg_update                one-cycle update strobe
// ---------------------------------------------------------------------------
module smc_apb_regbank #(
    parameter int          NUM_CS      = 4,
    parameter int          ADDR_W      = 5,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] CFG_RST     = 32'h0000_0000
) (
    input  logic                   i_pclk,
    input  logic                   i_preset,
    input  logic                   i_psel,
    input  logic                   i_penable,
    input  logic                   i_pwrite,
    input  logic [ADDR_W-1:0]      i_paddr,
    input  logic [31:0]            i_pwdata,
    input  logic [31:0]            i_smc_status,
    output logic [31:0]            o_prdata,
    output logic                   o_pready,
    output logic                   o_pslverr,
    output logic [32*NUM_CS-1:0]   o_cfg_regs,
    output logic                   o_cfg_lock,
    output logic                   o_cfg_update
);

    localparam int               IDX_W      = ADDR_W - 2;
    localparam logic [IDX_W-1:0] CTRL_IDX   = IDX_W'(NUM_CS);
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_CS + 1);
    localparam logic [1:0]       CNT_INIT   = 2'(WAIT_STATES);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_nxt;
    logic             w_done;
    logic             r_lock;
    logic             r_update;
    logic [31:0]      r_cfg [NUM_CS];

    logic [IDX_W-1:0] w_idx;
    logic             w_is_cfg;
    logic             w_is_ctrl;
    logic             w_is_status;
    logic             w_mapped;
    logic             w_wr;
    logic             w_pready;
    logic [31:0]      w_rdata;
    logic             w_unused_addr;

    // Byte-lane bits carry no meaning for a word-only register bank.
    assign w_unused_addr = ^i_paddr[1:0];

    assign w_idx       = i_paddr[ADDR_W-1:2];
    assign w_is_cfg    = (w_idx < CTRL_IDX);
    assign w_is_ctrl   = (w_idx == CTRL_IDX);
    assign w_is_status = (w_idx == STATUS_IDX);
    assign w_mapped    = w_is_cfg | w_is_ctrl | w_is_status;

    // ------------------------------------------------------------------
    // Access FSM: next state and completion
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_psel && !i_penable) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            ST_ACCESS: begin
                if (!i_psel) begin
                    // Master abandoned the transfer: leave without side effects.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 2'd0;
                end else if (i_penable && (r_cnt == 2'd0)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt != 2'd0) begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Gating with reset keeps the APB outputs quiet during the reset cycle
    // itself, including one that interrupts an access in flight.
    assign w_pready = (r_state == ST_ACCESS) && (r_cnt == 2'd0) && !i_preset;
    assign w_wr     = w_done && i_pwrite;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_lock   <= 1'b0;
            r_update <= 1'b0;
            for (int i = 0; i < NUM_CS; i++) begin
                r_cfg[i] <= CFG_RST;
            end
        end else begin
            r_update <= w_wr && w_is_ctrl && i_pwdata[1];
            if (w_wr && w_is_ctrl && i_pwdata[0]) begin
                r_lock <= 1'b1;
            end
            for (int i = 0; i < NUM_CS; i++) begin
                if (w_wr && w_is_cfg && !r_lock && (w_idx == IDX_W'(i))) begin
                    r_cfg[i] <= i_pwdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = 32'h0;
        if (w_is_cfg) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (w_idx == IDX_W'(i)) begin
                    w_rdata = r_cfg[i];
                end
            end
        end else if (w_is_ctrl) begin
            // UPDATE is a strobe and always reads back as zero.
            w_rdata = {30'h0, 1'b0, r_lock};
        end else if (w_is_status) begin
            w_rdata = i_smc_status;
        end
    end

    assign o_prdata = (w_pready && !i_pwrite) ? w_rdata : 32'h0;
    assign o_pready = w_pready;

`ifdef SMC_APB_PSLVERR_EN
    logic w_err;
    assign w_err     = !w_mapped
                     || (i_pwrite && w_is_status)
                     || (i_pwrite && w_is_cfg && r_lock);
    assign o_pslverr = w_pready && w_err;
`else
    logic w_unused_map;
    assign w_unused_map = w_mapped;
    assign o_pslverr    = 1'b0;
`endif

    generate
        for (genvar g = 0; g < NUM_CS; g++) begin : g_cfg_out
            assign o_cfg_regs[32*g +: 32] = r_cfg[g];
        end
    endgenerate

    assign o_cfg_lock   = r_lock;
    assign o_cfg_update = r_update;

endmodule

// File: tb/tb_smc_apb_regbank.sv
// ---------------------------------------------------------------------------
// tb_smc_apb_regbank
//   Scoreboard bench for smc_apb_regbank with the default parameters
//   (NUM_CS=4, ADDR_W=5, WAIT_STATES=1, CFG_RST=0). Each APB transfer pushes
//   its expected read data and error response when it is driven; a monitor
//   pops and compares when the DUT completes the transfer.
// ---------------------------------------------------------------------------
module tb_smc_apb_regbank;

    logic          clk;
    logic          preset;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [4:0]    paddr;
    logic [31:0]   pwdata;
    logic [31:0]   smc_status;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;
    logic [127:0]  cfg_regs;
    logic          cfg_lock;
    logic          cfg_update;

`ifdef SMC_APB_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    smc_apb_regbank #(
        .NUM_CS      (4),
        .ADDR_W      (5),
        .WAIT_STATES (1),
        .CFG_RST     (32'h0000_0000)
    ) u_dut (
        .i_pclk       (clk),
        .i_preset     (preset),
        .i_psel       (psel),
        .i_penable    (penable),
        .i_pwrite     (pwrite),
        .i_paddr      (paddr),
        .i_pwdata     (pwdata),
        .i_smc_status (smc_status),
        .o_prdata     (prdata),
        .o_pready     (pready),
        .o_pslverr    (pslverr),
        .o_cfg_regs   (cfg_regs),
        .o_cfg_lock   (cfg_lock),
        .o_cfg_update (cfg_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_cfg [4];
    logic        m_lock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Completion monitor: one scoreboard entry per completed transfer.
    always @(negedge clk) begin
        if (psel && penable && pready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (!e.wr) check("prdata", prdata, e.rd);
                check("pslverr", 32'(pslverr), 32'(e.err));
            end
        end else if (psel && penable) begin
            check("prdata_wait", prdata, 32'h0);
            check("pslverr_wait", 32'(pslverr), 32'h0);
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the completion edge.
    task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, output int waits);
        int k;
        bit done;
        sb.push_back('{wr: w, rd: exp_rd, err: exp_err});
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        k     = 0;
        while (!done && k < 16) begin
            @(negedge clk);
            if (pready) begin
                done = 1'b1;
            end else begin
                waits++;
                @(posedge clk); #1;
            end
            k++;
        end
        if (!done) check("xfer_timeout", 32'(pready), 32'd1);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    function automatic logic is_err(input logic w, input logic [4:0] a);
        logic [2:0] idx;
        idx = a[4:2];
        if (idx > 3'd5) return ERR_EN;
        if (w && idx == 3'd5) return ERR_EN;
        if (w && idx < 3'd4 && m_lock) return ERR_EN;
        return 1'b0;
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        int wt;
        logic e;
        e = is_err(1'b1, a);
        xfer(1'b1, a, d, 32'h0, e, wt);
        if (a[4:2] < 3'd4 && !m_lock) m_cfg[a[3:2]] = d;
        if (a[4:2] == 3'd4 && d[0]) m_lock = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a);
        int wt;
        logic [31:0] x;
        case (a[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: x = m_cfg[a[3:2]];
            3'd4:                   x = {31'h0, m_lock};
            3'd5:                   x = smc_status;
            default:                x = 32'h0;
        endcase
        xfer(1'b0, a, 32'h0, x, is_err(1'b0, a), wt);
    endtask

    task automatic chk_cfg();
        for (int i = 0; i < 4; i++)
            check($sformatf("cfg%0d", i), cfg_regs[32*i +: 32], m_cfg[i]);
        check("lock", 32'(cfg_lock), 32'(m_lock));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cfg[i] = 32'h0;
        m_lock = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; smc_status = 32'h0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_update", 32'(cfg_update), 32'h0);
        chk_cfg();
        @(posedge clk); #1 preset = 1'b0;

        // CFG2 write/read with wait-state timing
        xfer(1'b1, 5'h08, 32'hA5A5_0003, 32'h0, 1'b0, wt);
        m_cfg[2] = 32'hA5A5_0003;
        check("wait_cycles", 32'(wt), 32'd1);
        check("cfg2_out", cfg_regs[95:64], 32'hA5A5_0003);
        check("no_update", 32'(cfg_update), 32'h0);
        xfer(1'b0, 5'h08, 32'h0, 32'hA5A5_0003, 1'b0, wt);

        // Back-to-back writes and reads of every CFG register
        for (int i = 0; i < 4; i++) wr(5'(4*i), $urandom());
        for (int i = 0; i < 4; i++) rd(5'(4*i));
        wr(5'h04, 32'h0000_0000);
        wr(5'h0C, 32'hFFFF_FFFF);
        rd(5'h04);
        rd(5'h0C);
        chk_cfg();

        // UPDATE strobe
        xfer(1'b1, 5'h10, 32'h0000_0002, 32'h0, 1'b0, wt);
        check("update_pulse", 32'(cfg_update), 32'd1);
        @(posedge clk); #1;
        check("update_clear", 32'(cfg_update), 32'h0);
        xfer(1'b0, 5'h10, 32'h0, 32'h0, 1'b0, wt);

        // STATUS and unmapped space
        smc_status = 32'hDEAD_BEEF;
        xfer(1'b0, 5'h14, 32'h0, 32'hDEAD_BEEF, 1'b0, wt);
        wr(5'h14, 32'h1234_5678);
        rd(5'h18);
        wr(5'h18, 32'h0000_0003);
        wr(5'h1C, 32'hCAFE_F00D);
        chk_cfg();
        rd(5'h14);

        // LOCK
        wr(5'h10, 32'h0000_0001);
        check("lock_set", 32'(cfg_lock), 32'd1);
        xfer(1'b1, 5'h00, 32'hFFFF_FFFF, 32'h0, ERR_EN, wt);
        check("cfg0_locked", cfg_regs[31:0], m_cfg[0]);
        wr(5'h10, 32'h0000_0000);
        rd(5'h10);
        chk_cfg();

        // Reset in the middle of a CFG1 write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h04; pwdata = 32'h1234;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk); preset = 1'b1;
        #1 check("rst_mid_pready", 32'(pready), 32'h0);
        @(posedge clk); #1 preset = 1'b0;
        model_reset();
        chk_cfg();
        // Held psel/penable without a setup phase must not start a transfer.
        repeat (3) begin
            @(negedge clk);
            check("idle_pready", 32'(pready), 32'h0);
        end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;

        // Abort: psel dropped while the access is waiting
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h04; pwdata = 32'h5555_5555;
        @(posedge clk); #1 psel = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_cfg();
        check("abort_pready", 32'(pready), 32'h0);

        // Recovery, then LOCK+UPDATE in one write
        wr(5'h04, 32'h0000_0077);
        rd(5'h04);
        xfer(1'b1, 5'h10, 32'h0000_0003, 32'h0, 1'b0, wt);
        m_lock = 1'b1;
        check("lu_update", 32'(cfg_update), 32'd1);
        check("lu_lock", 32'(cfg_lock), 32'd1);
        @(posedge clk); #1;
        check("lu_update_clr", 32'(cfg_update), 32'h0);
        chk_cfg();

        repeat (2) @(posedge clk);
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
